// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file (2R/1W) with a per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN forwards the writeback port onto the read ports in the same cycle.
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    output logic [AW:0]     busy_count
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [AW:0]      busy_count_r;

    logic             we_s;
    logic             set_s;
    logic             set_new_s;
    logic             clr_new_s;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      count_nxt_s;

    // Decode write/issue strobes and next scoreboard state; set is applied last so it wins.
    always_comb begin
        we_s        = RegWrite & (rd != {AW{1'b0}});
        set_s       = issue_valid & (issue_rd != {AW{1'b0}});
        busy_nxt_s  = busy_r;
        set_new_s   = 1'b0;
        clr_new_s   = 1'b0;
        if (we_s) begin
            busy_nxt_s[rd] = 1'b0;
            clr_new_s      = busy_r[rd] & ~(set_s & (issue_rd == rd));
        end else begin
            clr_new_s      = 1'b0;
        end
        if (set_s) begin
            busy_nxt_s[issue_rd] = 1'b1;
            set_new_s            = ~busy_r[issue_rd];
        end else begin
            set_new_s            = 1'b0;
        end
        count_nxt_s = busy_count_r + {{AW{1'b0}}, set_new_s} - {{AW{1'b0}}, clr_new_s};
    end

    // Architectural register storage; x0 is never written and so stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we_s) begin
            regs_r[rd] <= WriteData;
        end
    end

    // Scoreboard bits and their running population count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r       <= {NREGS{1'b0}};
            busy_count_r <= {(AW+1){1'b0}};
        end else begin
            busy_r       <= busy_nxt_s;
            busy_count_r <= count_nxt_s;
        end
    end

    assign busy_count = busy_count_r;

    // Read ports and busy flags, optionally forwarding the in-flight writeback.
    always_comb begin
        ReadData1 = regs_r[rs1];
        ReadData2 = regs_r[rs2];
        busy1     = busy_r[rs1];
        busy2     = busy_r[rs2];
`ifdef WB_BYPASS_EN
        if (we_s && (rs1 == rd)) begin
            ReadData1 = WriteData;
            busy1     = set_s & (issue_rd == rd);
        end else begin
            ReadData1 = regs_r[rs1];
            busy1     = busy_r[rs1];
        end
        if (we_s && (rs2 == rd)) begin
            ReadData2 = WriteData;
            busy2     = set_s & (issue_rd == rd);
        end else begin
            ReadData2 = regs_r[rs2];
            busy2     = busy_r[rs2];
        end
`else
        ReadData1 = regs_r[rs1];
        ReadData2 = regs_r[rs2];
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard plus hand-written reset and bypass sequences.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1, rs2, issue_rd, rd;
    logic [63:0] ReadData1, ReadData2, WriteData;
    logic        busy1, busy2, issue_valid, RegWrite;
    logic [5:0]  busy_count;

    int checks;
    int errors;

    regfile_scoreboard #(.XLEN(64), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .busy1(busy1), .busy2(busy2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rd(rd), .WriteData(WriteData),
        .RegWrite(RegWrite), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iv;
        logic [4:0]  ird;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; issue_valid = 1'b0; issue_rd = 5'd0;
        rd = 5'd0; WriteData = 64'd0; RegWrite = 1'b0;

        // rs1/rs2/iv/ird/we/rd/wd -> ReadData1/ReadData2/busy1/busy2/busy_count after the edge
        vecs[0]  = '{5'd0,  5'd1,  1'b0, 5'd0,  1'b0, 5'd0,  64'd0,
                     64'd0, 64'd0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{5'd5,  5'd0,  1'b0, 5'd0,  1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567,
                     64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{5'd5,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  64'h1,
                     64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{5'd7,  5'd5,  1'b1, 5'd7,  1'b0, 5'd0,  64'd0,
                     64'd0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 6'd1};
        vecs[4]  = '{5'd7,  5'd0,  1'b0, 5'd0,  1'b1, 5'd7,  64'h77,
                     64'h77, 64'd0, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{5'd9,  5'd7,  1'b1, 5'd9,  1'b0, 5'd0,  64'd0,
                     64'd0, 64'h77, 1'b1, 1'b0, 6'd1};
        vecs[6]  = '{5'd9,  5'd7,  1'b1, 5'd9,  1'b1, 5'd9,  64'h99,
                     64'h99, 64'h77, 1'b1, 1'b0, 6'd1};
        vecs[7]  = '{5'd0,  5'd9,  1'b1, 5'd0,  1'b0, 5'd0,  64'd0,
                     64'd0, 64'h99, 1'b0, 1'b1, 6'd1};
        vecs[8]  = '{5'd9,  5'd10, 1'b1, 5'd10, 1'b1, 5'd9,  64'h9A,
                     64'h9A, 64'd0, 1'b0, 1'b1, 6'd1};
        vecs[9]  = '{5'd10, 5'd9,  1'b1, 5'd10, 1'b0, 5'd0,  64'd0,
                     64'd0, 64'h9A, 1'b1, 1'b0, 6'd1};
        vecs[10] = '{5'd11, 5'd10, 1'b0, 5'd0,  1'b1, 5'd11, 64'h11,
                     64'h11, 64'd0, 1'b0, 1'b1, 6'd1};
        vecs[11] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF,
                     64'd0, 64'd0, 1'b0, 1'b0, 6'd1};
        vecs[12] = '{5'd31, 5'd1,  1'b1, 5'd1,  1'b1, 5'd31, 64'h1F,
                     64'h1F, 64'd0, 1'b0, 1'b1, 6'd2};

        // Reset held: every index reads zero, nothing busy.
        #3;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            chk("rst_rd1", ReadData1, 64'd0);
            chk("rst_rd2", ReadData2, 64'd0);
            chk("rst_busy1", {63'd0, busy1}, 64'd0);
        end
        chk("rst_count", {58'd0, busy_count}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_count", {58'd0, busy_count}, 64'd0);

        for (int v = 0; v < 13; v++) begin
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
            issue_valid = vecs[v].iv; issue_rd = vecs[v].ird;
            RegWrite = vecs[v].we; rd = vecs[v].rd; WriteData = vecs[v].wd;
            @(posedge clk); #1;
            issue_valid = 1'b0; RegWrite = 1'b0;
            #1;
            chk($sformatf("v%0d_rd1", v), ReadData1, vecs[v].e1);
            chk($sformatf("v%0d_rd2", v), ReadData2, vecs[v].e2);
            chk($sformatf("v%0d_busy1", v), {63'd0, busy1}, {63'd0, vecs[v].eb1});
            chk($sformatf("v%0d_busy2", v), {63'd0, busy2}, {63'd0, vecs[v].eb2});
            chk($sformatf("v%0d_count", v), {58'd0, busy_count}, {58'd0, vecs[v].ecnt});
        end

        // Issue 3 and 4, then drop reset between edges: state clears without a clock.
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(posedge clk); #1;
        issue_rd = 5'd4;
        @(posedge clk); #1;
        issue_rd = 5'd5; issue_valid = 1'b0;
        rs1 = 5'd3; rs2 = 5'd31;
        #1;
        chk("pre_rst_count", {58'd0, busy_count}, 64'd4);
        chk("pre_rst_busy1", {63'd0, busy1}, 64'd1);
        chk("pre_rst_rd2", ReadData2, 64'h1F);
        reset = 1'b0;
        #1;
        chk("async_rst_count", {58'd0, busy_count}, 64'd0);
        chk("async_rst_busy1", {63'd0, busy1}, 64'd0);
        chk("async_rst_rd2", ReadData2, 64'd0);
        rs1 = 5'd5;
        #1;
        chk("async_rst_rd1", ReadData1, 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_release_count", {58'd0, busy_count}, 64'd0);

        // Same-cycle read of the register being written.
        rs1 = 5'd12; rs2 = 5'd0;
        RegWrite = 1'b1; rd = 5'd12; WriteData = 64'hA5;
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass_rd1", ReadData1, 64'hA5);
`else
        chk("nobypass_rd1", ReadData1, 64'd0);
`endif
        chk("bypass_x0_rd2", ReadData2, 64'd0);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        chk("wb12_rd1", ReadData1, 64'hA5);
        chk("wb12_count", {58'd0, busy_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
